// File: rtl/top.sv
// Two-stage (IF -> EX/WB) RV32 subset core with instruction ROM and data RAM.
// Optional feature: define TOP_BNE_EN to decode BNE; otherwise BNE executes as a NOP.
module top #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter string       IMEM_FILE  = "imem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] start_pc,
  output logic [31:0] pc_out,
  output logic [31:0] a0_out,
  output logic [31:0] a1_out
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];

  logic [31:0] pc_q, ex_pc_q, ex_instr_q;

  // Decode fields of the EX-stage instruction
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ex_instr_q[6:0];
  assign rd     = ex_instr_q[11:7];
  assign funct3 = ex_instr_q[14:12];
  assign rs1    = ex_instr_q[19:15];
  assign rs2    = ex_instr_q[24:20];
  assign funct7 = ex_instr_q[31:25];

  assign imm_i = {{20{ex_instr_q[31]}}, ex_instr_q[31:20]};
  assign imm_s = {{20{ex_instr_q[31]}}, ex_instr_q[31:25], ex_instr_q[11:7]};
  assign imm_b = {{19{ex_instr_q[31]}}, ex_instr_q[31], ex_instr_q[7], ex_instr_q[30:25],
                  ex_instr_q[11:8], 1'b0};
  assign imm_u = {ex_instr_q[31:12], 12'b0};
  assign imm_j = {{11{ex_instr_q[31]}}, ex_instr_q[31], ex_instr_q[19:12], ex_instr_q[20],
                  ex_instr_q[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  logic        wb_en, mem_we, redirect;
  logic [31:0] wb_data, target, mem_addr, load_data;

  assign load_data = dmem[mem_addr[DAW+1:2]];

  always_comb begin
    wb_en    = 1'b0;
    wb_data  = 32'd0;
    mem_we   = 1'b0;
    mem_addr = rs1_val + imm_i;
    redirect = 1'b0;
    target   = ex_pc_q + imm_b;
    unique case (opcode)
      OpR: begin
        wb_en = 1'b1;
        if (funct7 == 7'b0000000 && funct3 == 3'd0) begin
          wb_data = rs1_val + rs2_val;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          wb_data = rs1_val - rs2_val;
        end else if (funct7 == 7'b0000000 && funct3 == 3'd7) begin
          wb_data = rs1_val & rs2_val;
        end else if (funct7 == 7'b0000000 && funct3 == 3'd6) begin
          wb_data = rs1_val | rs2_val;
        end else if (funct7 == 7'b0000000 && funct3 == 3'd2) begin
          wb_data = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
        end else begin
          wb_en = 1'b0;
        end
      end
      OpImm: begin
        wb_en   = (funct3 == 3'd0);
        wb_data = rs1_val + imm_i;
      end
      OpLui: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OpLoad: begin
        wb_en   = (funct3 == 3'd2);
        wb_data = load_data;
      end
      OpStore: begin
        mem_addr = rs1_val + imm_s;
        mem_we   = (funct3 == 3'd2);
      end
      OpBranch: begin
        if (funct3 == 3'd0) redirect = (rs1_val == rs2_val);
`ifdef TOP_BNE_EN
        if (funct3 == 3'd1) redirect = (rs1_val != rs2_val);
`endif
      end
      OpJal: begin
        wb_en    = 1'b1;
        wb_data  = ex_pc_q + 32'd4;
        redirect = 1'b1;
        target   = ex_pc_q + imm_j;
      end
      default: ;
    endcase
    if (rd == 5'd0) wb_en = 1'b0;
  end

  // A redirect squashes the instruction currently being fetched
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= start_pc;
      ex_pc_q    <= 32'd0;
      ex_instr_q <= Nop;
    end else begin
      ex_pc_q    <= pc_q;
      ex_instr_q <= redirect ? Nop : imem[pc_q[IAW+1:2]];
      pc_q       <= redirect ? target : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (wb_en) begin
      regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) dmem[mem_addr[DAW+1:2]] <= rs2_val;
  end

  logic unused_bits;
  assign unused_bits = ^{pc_q[31:IAW+2], pc_q[1:0], mem_addr[31:DAW+2], mem_addr[1:0],
                         regs[0]};

  assign pc_out = pc_q;
  assign a0_out = regs[10];
  assign a1_out = regs[11];

endmodule

// File: tb/tb_top.sv
// Directed bench for the two-stage core: programs the ROM hierarchically, checks pc/a0/a1.
module tb_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] start_pc = 32'd0;
  logic [31:0] pc_out, a0_out, a1_out;
  int checks = 0;
  int errors = 0;

  top #(.IMEM_WORDS(256), .DMEM_WORDS(256), .IMEM_FILE("")) dut (
    .clk      (clk),
    .rst      (rst),
    .start_pc (start_pc),
    .pc_out   (pc_out),
    .a0_out   (a0_out),
    .a1_out   (a1_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0000_0013;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    dut.imem[addr[9:2]] = word;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    start_pc = pc;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // BEQ not taken
    clear_imem();
    put(32'h74, 32'h00B5_0063);
    do_reset(32'h74);
    check("reset_pc", pc_out, 32'h74);
    check("reset_a0", a0_out, 32'h0A);
    check("reset_a1", a1_out, 32'h0B);
    step();
    check("bnt_pc1", pc_out, 32'h78);
    step();
    check("bnt_pc2", pc_out, 32'h7C);
    check("bnt_a0", a0_out, 32'h0A);
    check("bnt_a1", a1_out, 32'h0B);

    // BEQ taken after a1 is set equal to a0
    clear_imem();
    put(32'h70, 32'h00A0_0593);
    put(32'h74, 32'hFEB5_0EE3);
    put(32'h78, 32'h0630_0513);
    do_reset(32'h70);
    check("bt_pc0", pc_out, 32'h70);
    step();
    check("bt_pc1", pc_out, 32'h74);
    step();
    check("bt_pc2", pc_out, 32'h78);
    check("bt_a1", a1_out, 32'h0A);
    step();
    check("bt_pc3", pc_out, 32'h70);
    step();
    check("bt_squash_a0", a0_out, 32'h0A);
    check("bt_pc4", pc_out, 32'h74);

    // Reset while the taken branch is in EX
    do_reset(32'h70);
    step();
    step();
    check("mid_pre_pc", pc_out, 32'h78);
    do_reset(32'h200);
    check("mid_pc", pc_out, 32'h200);
    check("mid_a0", a0_out, 32'h0A);
    check("mid_a1", a1_out, 32'h0B);
    step();
    check("mid_pc_next", pc_out, 32'h204);

    // ALU and x0
    clear_imem();
    put(32'h00, 32'hFFF0_0293);
    put(32'h04, 32'h0052_8533);
    put(32'h08, 32'h4050_05B3);
    put(32'h0C, 32'h0070_0013);
    put(32'h10, 32'h0000_0533);
    put(32'h14, 32'h0050_25B3);
    put(32'h18, 32'h0002_E533);
    put(32'h1C, 32'h00E6_F533);
    do_reset(32'h0);
    repeat (4) step();
    check("alu_add", a0_out, 32'hFFFF_FFFE);
    check("alu_sub", a1_out, 32'h0000_0001);
    repeat (2) step();
    check("alu_x0", a0_out, 32'h0);
    step();
    check("alu_slt", a1_out, 32'h0);
    step();
    check("alu_or", a0_out, 32'hFFFF_FFFF);
    step();
    check("alu_and", a0_out, 32'h0000_000C);

    // Memory, including address wrap
    clear_imem();
    put(32'h100, 32'h1234_5337);
    put(32'h104, 32'h0060_2423);
    put(32'h108, 32'h0080_2503);
    put(32'h10C, 32'hC080_2583);
    do_reset(32'h100);
    repeat (4) step();
    check("mem_lw", a0_out, 32'h1234_5000);
    step();
    check("mem_wrap", a1_out, 32'h1234_5000);

    // JAL
    clear_imem();
    put(32'h10, 32'h0100_05EF);
    put(32'h14, 32'h0630_0513);
    put(32'h20, 32'h0050_0513);
    do_reset(32'h10);
    step();
    check("jal_pc1", pc_out, 32'h14);
    step();
    check("jal_pc2", pc_out, 32'h20);
    check("jal_link", a1_out, 32'h14);
    step();
    check("jal_squash", a0_out, 32'h0A);
    step();
    check("jal_target", a0_out, 32'h05);

    // BNE
    clear_imem();
    put(32'h40, 32'hFEB5_1CE3);
    do_reset(32'h40);
    step();
    step();
`ifdef TOP_BNE_EN
    check("bne_pc", pc_out, 32'h38);
`else
    check("bne_pc", pc_out, 32'h48);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
